// File: rtl/student_muxnway_rr.sv
// student_muxnway_rr
//   WAYS-input, WIDTH-bit channel selector with valid/ready handshakes and a
//   registered output stage. Mode 0 forwards the channel picked by `sel`;
//   mode 1 arbitrates round-robin across the valid channels.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   mode                 0 = fixed select, 1 = round-robin
//   sel                  channel select (mode 0 only)
//   in_data/in_valid     WAYS packed input channels, channel i at [i*WIDTH +: WIDTH]
//   in_ready             per-channel ready (combinational)
//   out_data/out_valid   registered output word and valid
//   out_ready            consumer ready
//   out_chan             channel that supplied out_data
//   xfer_count           accepted input beats since reset (wraps)

module student_muxnway_rr #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned WAYS  = 8,
  parameter int unsigned SEL_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [WAYS*WIDTH-1:0]   in_data,
  input  logic [WAYS-1:0]         in_valid,
  output logic [WAYS-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_chan,
  output logic [CNT_W-1:0]        xfer_count
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en;
  logic [SEL_W-1:0] grant;
  logic             rr_found;
  logic             sel_ok;
  logic             gvalid;
  logic [WIDTH-1:0] gword;
  logic             rdy_en;
  logic             xfer;
  int unsigned      idx;

  always_comb begin
    load_en  = !out_valid_q || out_ready;
    sel_ok   = (32'(sel) < WAYS);
    grant    = '0;
    rr_found = 1'b0;
    idx      = 0;

    if (!mode) begin
      grant = sel;
    end else begin
      // First valid channel at or after ptr, wrapping at WAYS.
      for (int unsigned k = 0; k < WAYS; k++) begin
        idx = (32'(ptr_q) + k) % WAYS;
        if (!rr_found && in_valid[idx]) begin
          rr_found = 1'b1;
          grant    = idx[SEL_W-1:0];
        end
      end
    end

    // Index through a compare loop so an out-of-range sel never addresses
    // beyond the WAYS channels.
    gvalid = 1'b0;
    gword  = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (SEL_W'(i) == grant) begin
        gvalid = in_valid[i];
        gword  = in_data[i*WIDTH +: WIDTH];
      end
    end

    rdy_en = rst_n && load_en && (mode ? rr_found : sel_ok);
    xfer   = rdy_en && gvalid;

    in_ready = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (SEL_W'(i) == grant) in_ready[i] = rdy_en;
    end

    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = gword;
        out_chan_d = grant;
      end
    end

    cnt_d = cnt_q + CNT_W'(xfer);

    ptr_d = ptr_q;
    if (xfer && mode) begin
      ptr_d = (grant == SEL_W'(WAYS - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_chan   = out_chan_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_student_muxnway_rr.sv
// Bench for student_muxnway_rr: an 8-way instance with a 4-bit beat counter
// (scoreboarded output beats plus direct state checks) and a 6-way instance
// for out-of-range select and non-power-of-two round-robin wrap.

module tb_student_muxnway_rr;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  chan;
    logic [3:0]  cnt;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic [2:0]   sel;
  logic [127:0] in_data;
  logic [7:0]   in_valid;
  logic [7:0]   in_ready;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_chan;
  logic [3:0]   xfer_count;

  logic         b_mode;
  logic [2:0]   b_sel;
  logic [95:0]  b_in_data;
  logic [5:0]   b_in_valid;
  logic [5:0]   b_in_ready;
  logic [15:0]  b_out_data;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [2:0]   b_out_chan;
  logic [15:0]  b_xfer_count;

  logic [15:0] chd [8] = '{16'h1234, 16'h2345, 16'h3456, 16'h4567,
                           16'h5678, 16'h6789, 16'h789A, 16'h89AB};

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] cnt    = '0;

  student_muxnway_rr #(.WIDTH(16), .WAYS(8), .SEL_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan), .xfer_count(xfer_count)
  );

  student_muxnway_rr #(.WIDTH(16), .WAYS(6), .SEL_W(3), .CNT_W(16)) dut6 (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_chan(b_out_chan), .xfer_count(b_xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch);
    cnt++;
    exp_q.push_back('{chd[ch], 3'(ch), cnt});
  endtask

  // Monitor: a beat is consumed when valid and ready are both high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data 0x%0h chan %0d, expected no beat",
                   out_data, out_chan);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_chan", out_chan, e.chan);
          chk("beat_count", xfer_count, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    int sparse[4] = '{2, 5, 2, 5};
    int w;

    for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = chd[i];
    for (int i = 0; i < 6; i++) b_in_data[i*16 +: 16] = chd[i];
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '1; out_ready = 1'b1;
    b_mode = 1'b0; b_sel = '0; b_in_valid = '0; b_out_ready = 1'b1;

    // Reset held two cycles with all channels valid.
    step(); step();
    chk("reset_in_ready", in_ready, 8'h00);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 16'h0);
    chk("reset_out_chan", out_chan, 3'd0);
    chk("reset_count", xfer_count, 4'd0);

    // Fixed-select sweep.
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      if (s == 0) chk("ready_after_release", in_ready, 8'h01);
      push(s);
      step();
    end
    chk("sweep_count", xfer_count, 4'd8);

    // Round-robin, all valid: 0..7,0,1.
    mode = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push(k % 8);
      step();
    end

    // Sparse round-robin: ptr is 2 here.
    in_valid = 8'b0010_0100;
    for (int k = 0; k < 4; k++) begin
      push(sparse[k]);
      step();
    end
    in_valid = 8'b0010_0000;
    push(5); step();
    push(5); step();
    // ptr must be 6 now, so channel 6 wins over channel 5.
    in_valid = 8'b0110_0000;
    push(6); step();

    // Backpressure.
    mode = 1'b0; sel = 3'd0; in_valid = '1;
    push(0); step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", in_ready, 8'h00);
      step();
      chk("stall_data", out_data, 16'h1234);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_count", xfer_count, cnt);
    end
    out_ready = 1'b1; sel = 3'd1;
    #1;
    chk("resume_in_ready", in_ready, 8'h02);
    push(1); step();

    // Reset mid-stream drops the held word.
    sel = 3'd2; step();
    chk("held_valid", out_valid, 1'b1);
    chk("held_data", out_data, 16'h3456);
    out_ready = 1'b0; rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", in_ready, 8'h00);
    step();
    chk("midreset_valid", out_valid, 1'b0);
    chk("midreset_data", out_data, 16'h0);
    chk("midreset_count", xfer_count, 4'd0);

    // Counter wrap: 17 beats into a 4-bit counter.
    rst_n = 1'b1; out_ready = 1'b1; cnt = '0;
    for (int k = 0; k < 17; k++) begin
      sel = 3'(k % 8);
      push(k % 8);
      step();
    end
    chk("wrap_count", xfer_count, 4'd1);
    in_valid = '0;
    step(); step();
    chk("idle_valid", out_valid, 1'b0);

    // Six-way instance: highest legal select, then out-of-range select.
    b_in_valid = '1; b_sel = 3'd5;
    #1;
    chk("w6_sel5_ready", b_in_ready, 6'h20);
    step();
    chk("w6_sel5_valid", b_out_valid, 1'b1);
    chk("w6_sel5_chan", b_out_chan, 3'd5);
    chk("w6_sel5_data", b_out_data, 16'h6789);
    b_sel = 3'd7;
    #1;
    chk("w6_sel7_ready", b_in_ready, 6'h00);
    step();
    chk("w6_sel7_valid", b_out_valid, 1'b0);
    chk("w6_sel7_chan", b_out_chan, 3'd5);
    chk("w6_sel7_data", b_out_data, 16'h6789);
    chk("w6_sel7_count", b_xfer_count, 16'd1);

    // Six-way round-robin wraps from channel 5 back to 0.
    b_mode = 1'b1; b_in_valid = 6'b10_0001;
    #1;
    chk("w6_rr_ready0", b_in_ready, 6'h01);
    step();
    chk("w6_rr_chan0", b_out_chan, 3'd0);
    chk("w6_rr_ready1", b_in_ready, 6'h20);
    step();
    chk("w6_rr_chan1", b_out_chan, 3'd5);
    chk("w6_rr_ready2", b_in_ready, 6'h01);
    step();
    chk("w6_rr_chan2", b_out_chan, 3'd0);
    chk("w6_rr_count", b_xfer_count, 16'd4);
    b_in_valid = '0;

    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      step();
      w++;
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
